// File: rtl/alu_pkg.sv
// Shared constants for the vector ALU: major opcode, function codes and
// element-width encodings.
package alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b101010;

  typedef enum logic [5:0] {
    FN_VAND   = 6'b000001,
    FN_VOR    = 6'b000010,
    FN_VXOR   = 6'b000011,
    FN_VNOT   = 6'b000100,
    FN_VMOV   = 6'b000101,
    FN_VADD   = 6'b000110,
    FN_VSUB   = 6'b000111,
    FN_VMULEU = 6'b001000,
    FN_VMULOU = 6'b001001,
    FN_VSLL   = 6'b001010,
    FN_VSRL   = 6'b001011,
    FN_VSRA   = 6'b001100,
    FN_VRTTH  = 6'b001101,
    FN_VDIV   = 6'b001110,
    FN_VMOD   = 6'b001111,
    FN_VSQEU  = 6'b010000,
    FN_VSQOU  = 6'b010001,
    FN_VSQRT  = 6'b010010
  } alu_fn_e;

  typedef enum logic [1:0] {
    WW_B = 2'b00,
    WW_H = 2'b01,
    WW_W = 2'b10,
    WW_D = 2'b11
  } alu_ww_e;

endpackage

// File: rtl/alu_isqrt.sv
// Combinational integer square root, digit-by-digit (two radicand bits per
// step); root_o = floor(sqrt(x_i)).
module alu_isqrt #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]   x_i,
  output logic [WIDTH/2-1:0] root_o
);

  // The partial remainder never exceeds twice the partial root, so it fits
  // in WIDTH/2+2 bits after the two-bit shift-in.
  always_comb begin
    logic [WIDTH/2+1:0] rem;
    logic [WIDTH/2+1:0] trial;
    logic [WIDTH/2-1:0] root;
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    rem   = '0;
    trial = '0;
    root  = '0;
    for (int i = WIDTH/2 - 1; i >= 0; i--) begin
      rem   = {rem[WIDTH/2-1:0], x_i[2*i +: 2]};
      trial = {root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[WIDTH/2-2:0], 1'b1};
      end else begin
        root = {root[WIDTH/2-2:0], 1'b0};
      end
    end
    root_o = root;
  end

endmodule

// File: rtl/alu.sv
// Registered 64-bit SIMD integer ALU. Buses are [0:63] with bit 0 as MSB;
// internally values are held as [63:0] so lane 0 sits at the top bits.
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [0:63] rA_64bit_val,
  input  logic [0:63] rB_64bit_val,
  input  logic [0:5]  R_ins,
  input  logic [0:5]  Op_code,
  input  logic [0:1]  WW,
  output logic [0:63] ALU_out
);

  logic [63:0]      a;
  logic [63:0]      b;
  logic [5:0]       r_ins;
  logic [3:0][63:0] width_res;
  logic [63:0]      alu_d;
  logic [63:0]      alu_q;

  assign a     = rA_64bit_val;
  assign b     = rB_64bit_val;
  assign r_ins = R_ins;

  // One lane-wise datapath per element width; lane l here is counted from
  // the LSB, so the even (MSB-side) lane of a pair is its upper half.
  for (genvar g = 0; g < 4; g++) begin : g_width
    localparam int W  = 8 << g;
    localparam int N  = 64 / W;
    localparam int SW = $clog2(W);

    logic [63:0] sqrt_v;
    logic [63:0] wide;
    logic [63:0] res;

    for (genvar l = 0; l < N; l++) begin : g_lane
      alu_isqrt #(.WIDTH(W)) u_isqrt (
        .x_i    (a[l*W +: W]),
        .root_o (sqrt_v[l*W +: W/2])
      );
      assign sqrt_v[l*W + W/2 +: W/2] = '0;
    end

    if (g < 3) begin : g_wide
      always_comb begin
        logic [W-1:0]   xa;
        logic [W-1:0]   xb;
        logic [2*W-1:0] pa;
        logic [2*W-1:0] pb;
        wide = '0;
        xa   = '0;
        xb   = '0;
        pa   = '0;
        pb   = '0;
        for (int p = 0; p < N/2; p++) begin
          if (r_ins == FN_VMULOU || r_ins == FN_VSQOU) begin
            xa = a[p*2*W +: W];
            xb = b[p*2*W +: W];
          end else begin
            xa = a[p*2*W + W +: W];
            xb = b[p*2*W + W +: W];
          end
          if (r_ins == FN_VSQEU || r_ins == FN_VSQOU) xb = xa;
          pa = '0;
          pb = '0;
          pa[W-1:0] = xa;
          pb[W-1:0] = xb;
          wide[p*2*W +: 2*W] = pa * pb;
        end
      end
    end else begin : g_no_wide
      // A 64-bit lane has no partner lane to widen into.
      assign wide = '0;
    end

    always_comb begin
      logic [W-1:0] la;
      logic [W-1:0] lb;
      res = '0;
      la  = '0;
      lb  = '0;
      for (int l = 0; l < N; l++) begin
        la = a[l*W +: W];
        lb = b[l*W +: W];
        case (r_ins)
          FN_VADD:  res[l*W +: W] = la + lb;
          FN_VSUB:  res[l*W +: W] = la - lb;
          FN_VSLL:  res[l*W +: W] = la << lb[SW-1:0];
          FN_VSRL:  res[l*W +: W] = la >> lb[SW-1:0];
          FN_VSRA:  res[l*W +: W] = $signed(la) >>> lb[SW-1:0];
          FN_VRTTH: res[l*W +: W] = {la[W/2-1:0], la[W-1:W/2]};
          FN_VDIV:  res[l*W +: W] = (lb == '0) ? '0 : la / lb;
          FN_VMOD:  res[l*W +: W] = (lb == '0) ? '0 : la % lb;
          FN_VSQRT: res[l*W +: W] = sqrt_v[l*W +: W];
          default:  ;
        endcase
      end
      if (r_ins inside {FN_VMULEU, FN_VMULOU, FN_VSQEU, FN_VSQOU}) res = wide;
    end

    assign width_res[g] = res;
  end

  always_comb begin
    alu_d = '0;
    if (Op_code == OP_RTYPE) begin
      case (r_ins)
        FN_VAND: alu_d = a & b;
        FN_VOR:  alu_d = a | b;
        FN_VXOR: alu_d = a ^ b;
        FN_VNOT: alu_d = ~a;
        FN_VMOV: alu_d = a;
        FN_VADD, FN_VSUB, FN_VMULEU, FN_VMULOU, FN_VSLL, FN_VSRL, FN_VSRA,
        FN_VRTTH, FN_VDIV, FN_VMOD, FN_VSQEU, FN_VSQOU, FN_VSQRT: begin
          case (WW)
            WW_B:    alu_d = width_res[0];
            WW_H:    alu_d = width_res[1];
            WW_W:    alu_d = width_res[2];
            default: alu_d = width_res[3];
          endcase
        end
        default: alu_d = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) alu_q <= '0;
    else          alu_q <= alu_d;
  end

  assign ALU_out = alu_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: expected results are queued as each operation
// is driven and compared one cycle later when the registered result appears.
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [0:63] rA_64bit_val;
  logic [0:63] rB_64bit_val;
  logic [0:5]  R_ins;
  logic [0:5]  Op_code;
  logic [0:1]  WW;
  logic [0:63] ALU_out;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  alu dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rA_64bit_val (rA_64bit_val),
    .rB_64bit_val (rB_64bit_val),
    .R_ins        (R_ins),
    .Op_code      (Op_code),
    .WW           (WW),
    .ALU_out      (ALU_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [5:0] fn, input logic [1:0] ww,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                       input logic [5:0] op = OP_RTYPE);
    @(negedge clk);
    Op_code      = op;
    R_ins        = fn;
    WW           = ww;
    rA_64bit_val = a;
    rB_64bit_val = b;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) check(tag_q.pop_front(), ALU_out, exp_q.pop_front());
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    Op_code      = OP_RTYPE;
    R_ins        = FN_VMOV;
    WW           = WW_D;
    rA_64bit_val = 64'hDEADBEEF_DEADBEEF;
    rB_64bit_val = '0;
    #12;
    check("reset_state", ALU_out, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    issue("vand",  FN_VAND, WW_W, 64'hF, 64'hE, 64'hE);
    issue("vor",   FN_VOR,  WW_W, 64'hF, 64'hE, 64'hF);
    issue("vxor",  FN_VXOR, WW_W, 64'hF, 64'hE, 64'h1);
    issue("vnot",  FN_VNOT, WW_W, 64'h0, 64'h0, 64'hFFFFFFFF_FFFFFFFF);
    issue("vmov",  FN_VMOV, WW_W, 64'hFFFFFFFF_00000000, 64'h0, 64'hFFFFFFFF_00000000);

    issue("vadd_b_small", FN_VADD, WW_B, 64'd5, 64'd10, 64'd15);
    issue("vadd_b_wrap",  FN_VADD, WW_B, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111, 64'hFFFFFFFF_10101010);
    issue("vadd_b_lanes", FN_VADD, WW_B, 64'hFFFFFFFF_FFFFFFFF, 64'h0000FFFF_11111111, 64'hFFFFFEFE_10101010);
    issue("vadd_d_wrap",  FN_VADD, WW_D, 64'hFFFFFFFF_FFFFFFFF, 64'h1, 64'h0);
    issue("vsub_w", FN_VSUB, WW_W, 64'hFFFFFFFF_FFFFFFFF, 64'h0F0F0F0F_11111111, 64'hF0F0F0F0_EEEEEEEE);
    issue("vsub_d", FN_VSUB, WW_D, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111, 64'hFFFFFFFF_EEEEEEEE);

    issue("vmuleu_h", FN_VMULEU, WW_H, 64'hFF000000_FFFFFFFF, 64'h00020000_000F0001, 64'h0001FE00_000EFFF1);
    issue("vmuleu_w", FN_VMULEU, WW_W, 64'h20, 64'h20, 64'h0);
    issue("vmulou_w", FN_VMULOU, WW_W, 64'h20, 64'h20, 64'h400);
    issue("vmuleu_d", FN_VMULEU, WW_D, 64'h5, 64'h5, 64'h0);
    issue("vsqeu_d",  FN_VSQEU,  WW_D, 64'h7, 64'h0, 64'h0);

    issue("vsll_b", FN_VSLL, WW_B, 64'h01010101_01010101, 64'h00010203_04050607, 64'h01020408_10204080);
    issue("vsrl_h", FN_VSRL, WW_H, 64'h80008000_80008000, 64'h0001000F_00100004, 64'h40000001_80000800);
    issue("vsra_w", FN_VSRA, WW_W, 64'h80000000_40000000, 64'h00000004_0000001F, 64'hF8000000_00000000);
    issue("vrtth_d", FN_VRTTH, WW_D, 64'hFFFFFFFF_00000000, 64'h0, 64'h00000000_FFFFFFFF);
    issue("vrtth_b", FN_VRTTH, WW_B, 64'h12345678_9ABCDEF0, 64'h0, 64'h21436587_A9CBED0F);

    issue("vdiv_b",   FN_VDIV, WW_B, 64'hFF00FF00_FF00FF00, 64'h11221122_44444444, 64'h0F000F00_03000300);
    issue("vmod_d",   FN_VMOD, WW_D, 64'd102, 64'd10, 64'd2);
    issue("vdiv_w_z", FN_VDIV, WW_W, 64'h00000064_00000064, 64'h00000000_00000007, 64'h00000000_0000000E);
    issue("vmod_w_z", FN_VMOD, WW_W, 64'h00000064_00000064, 64'h00000000_00000007, 64'h00000000_00000002);

    issue("vsqeu_w", FN_VSQEU, WW_W, 64'h00000040_00000001, 64'h0, 64'h1000);
    issue("vsqou_w", FN_VSQOU, WW_W, 64'h00000040_00000001, 64'h0, 64'h1);
    issue("vsqeu_b", FN_VSQEU, WW_B, 64'hFF010000_00000000, 64'h0, 64'hFE010000_00000000);
    issue("vsqou_b", FN_VSQOU, WW_B, 64'hFF010000_00000000, 64'h0, 64'h00010000_00000000);
    issue("vsqrt_w", FN_VSQRT, WW_W, 64'h00000040_00000001, 64'h0, 64'h00000008_00000001);
    issue("vsqrt_b", FN_VSQRT, WW_B, 64'hFF000104_091064C8, 64'h0, 64'h0F000102_03040A0E);
    issue("vsqrt_d", FN_VSQRT, WW_D, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 64'h00000000_FFFFFFFF);

    issue("bad_opcode", FN_VADD, WW_B, 64'd5, 64'd10, 64'h0, 6'b000000);
    issue("bad_fn_13",  6'b010011, WW_W, 64'hFF, 64'hFF, 64'h0);
    issue("bad_fn_00",  6'b000000, WW_W, 64'hFF, 64'hFF, 64'h0);
    issue("pre_reset",  FN_VMOV, WW_D, 64'h12345678_9ABCDEF0, 64'h0, 64'h12345678_9ABCDEF0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_before_reset", 64'(exp_q.size()), 64'h0);

    // Asynchronous clear between edges, then hold while inputs keep changing.
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_async", ALU_out, 64'h0);
    rA_64bit_val = 64'hAAAAAAAA_55555555;
    @(posedge clk);
    #1;
    check("reset_hold", ALU_out, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    issue("post_reset", FN_VXOR, WW_D, 64'hAAAAAAAA_55555555, 64'hFFFFFFFF_FFFFFFFF, 64'h55555555_AAAAAAAA);
    issue("post_reset_add", FN_VADD, WW_H, 64'hFFFF0001_7FFF8000, 64'h00010001_00018000, 64'h00000002_80000000);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("drain_end", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Registered 64-bit SIMD integer ALU for the vector datapath's execute stage. Decodes R-type vector instructions (`Op_code` = 6'b101010) by their `R_ins` function field. Operates lane-wise on 8/16/32/64-bit elements selected by `WW`. The result is registered once on the clock.

## Interface
- No parameters. Bit 0 is the MSB on every bus, declared `[0:n]`.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rA_64bit_val` in 64: operand A.
- `rB_64bit_val` in 64: operand B.
- `R_ins` in 6: function code.
- `Op_code` in 6: major opcode.
- `WW` in 2: element width. 00=8b, 01=16b, 10=32b, 11=64b.
- `ALU_out` out 64: registered result.

## Operation
- Lanes are numbered from bit 0. Lane 0 holds the most significant element and is the "even" element.
- All arithmetic is unsigned and wraps modulo the lane width. No carry or borrow crosses a lane.
- Function codes and results:
  - 000001 VAND: A&B.
  - 000010 VOR: A|B.
  - 000011 VXOR: A^B.
  - 000100 VNOT: ~A.
  - 000101 VMOV: A. `WW` is ignored for these five codes.
  - 000110 VADD: A+B per lane.
  - 000111 VSUB: A−B per lane.
  - 001000 VMULEU: each even lane of A times the matching even lane of B. The 2W-bit product fills that lane pair.
  - 001001 VMULOU: same as VMULEU, using odd lanes.
  - 001010 VSLL: logical left shift per lane.
  - 001011 VSRL: logical right shift per lane.
  - 001100 VSRA: arithmetic right shift per lane.
  - For the three shifts, the amount is the low log2(W) bits of the same lane of B.
  - 001101 VRTTH: rotate each lane by W/2, which swaps its halves.
  - 001110 VDIV: floor(A/B) per lane.
  - 001111 VMOD: A mod B per lane.
  - 010000 VSQEU: square of each even lane of A, widened to 2W.
  - 010001 VSQOU: square of each odd lane of A, widened to 2W.
  - 010010 VSQRT: floor(sqrt(A)) per lane.
- Boundary rules:
  - VMULEU, VMULOU, VSQEU and VSQOU with `WW`=11 produce 0.
  - Divide by zero in a lane produces 0 in that lane, for both VDIV and VMOD.
  - Any `Op_code` other than 101010, or any unlisted `R_ins`, produces 0.

## Timing
- One cycle of latency. `ALU_out` is loaded on every rising `clk` with the combinational result of the inputs present at that edge.
- There is no handshake or stall, and a new operation can be issued every cycle.
- `reset_n` low clears `ALU_out` to 0 immediately and holds it at 0 while asserted.
- After `reset_n` deasserts, the first edge captures the current inputs.
- Reset asserted mid-stream discards the pending result.

## Structure
- `alu_pkg`:
  - Constant `OP_RTYPE` = 6'b101010.
  - All 18 function-code constants.
  - WW encodings `WW_B`, `WW_H`, `WW_W`, `WW_D`.
- Sub-module `alu_isqrt`: a combinational 64-bit integer square root, instantiated once per lane width, or as a shared function.
- Lane operations are generated per width and muxed by `WW`.
- One output register.

## Test plan
- Logic and move, WW=10:
  - VAND 15,14 -> 14.
  - VOR -> 15.
  - VXOR -> 1.
  - VNOT A=0 -> FFFFFFFF_FFFFFFFF.
  - VMOV A=FFFFFFFF_00000000 -> same.
- VADD, WW=00:
  - 5+10 -> 15.
  - FFFFFFFF_FFFFFFFF + 00000000_11111111 -> FFFFFFFF_10101010.
  - FFFFFFFF_FFFFFFFF + 0000FFFF_11111111 -> FFFFFEFE_10101010.
- VSUB, A=FFFFFFFF_FFFFFFFF:
  - WW=10, B=0F0F0F0F_11111111 -> F0F0F0F0_EEEEEEEE.
  - WW=11, B=00000000_11111111 -> FFFFFFFF_EEEEEEEE.
- Multiply, WW=01, A=FF000000_FFFFFFFF, B=00020000_000F0001:
  - VMULEU -> 0001FE00_000EFFF1.
- Multiply, WW=10, A=B=20:
  - VMULEU -> 0.
  - VMULOU -> 400.
- Divide and modulo:
  - VDIV WW=00, A=FF00FF00_FF00FF00, B=11221122_44444444 -> 0F000F00_03000300.
  - VMOD WW=11, 102 mod 10 -> 2.
  - Any lane with B=0 -> 0 in that lane.
- Rotate, square, root and reset:
  - VRTTH WW=11, A=FFFFFFFF_00000000 -> 00000000_FFFFFFFF.
  - WW=10, A=00000040_00000001: VSQEU -> 0x1000, VSQOU -> 1, VSQRT -> 00000008_00000001.
  - `reset_n` pulsed low -> `ALU_out`=0 with no clock edge required.
